// File: rtl/bsarb_pkg.sv
// bsarb_pkg: shared state encoding and byte-stream framing codes for the byte stream arbiter.
package bsarb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
  localparam logic [7:0] BS_SOP  = 8'h7A;
  localparam logic [7:0] BS_EOP  = 8'h7B;
  localparam logic [7:0] BS_CHAN = 8'h7C;
  localparam logic [7:0] BS_ESC  = 8'h7D;
endpackage

// File: rtl/byte_stream_arbiter_tracker.sv
// bytes_eop_tracker: flags the final byte of a framed packet (EOP marker, then one possibly-escaped byte).
module bytes_eop_tracker
  import bsarb_pkg::*;
(
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       clr,
  input  logic       xfer,
  input  logic [7:0] data,
  output logic       last
);
  logic eop_q, eop_d, esc_q, esc_d;
  // eop_q&esc_q: escaped final byte pending; esc_q alone: next byte is a literal
  assign last = xfer & eop_q & (esc_q | data != BS_ESC);
  always_comb begin
    eop_d = eop_q;
    esc_d = esc_q;
    if (clr || last) begin
      eop_d = 1'b0;
      esc_d = 1'b0;
    end else if (xfer) begin
      eop_d = eop_q | (!esc_q && data == BS_EOP);
      esc_d = eop_q ? 1'b1 : (!esc_q && data == BS_ESC);
    end
  end
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      eop_q <= 1'b0;
      esc_q <= 1'b0;
    end else begin
      eop_q <= eop_d;
      esc_q <= esc_d;
    end
endmodule

// File: rtl/byte_stream_arbiter.sv
// byte_stream_arbiter: round-robin sharing of one bridge byte-stream pair between NUM_REQ hosts.
// Optional response watchdog enabled by defining BSARB_TIMEOUT_EN.
module byte_stream_arbiter
  import bsarb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [8*NUM_REQ-1:0]       rsp_data,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic                       bus_in_valid,
  output logic [7:0]                 bus_in_data,
  input  logic                       bus_in_ready,
  input  logic                       bus_out_valid,
  input  logic [7:0]                 bus_out_data,
  output logic                       bus_out_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_pulse
);
  localparam int GW = $clog2(NUM_REQ);
  state_e state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, rr_q, rr_d, pick, cand, next_g;
  logic trk_xfer, trk_clr, trk_last, tmo;
  logic [7:0] trk_data;
  always_comb begin
    pick = rr_q;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = GW'((int'(rr_q) + k) % NUM_REQ);
      if (req_valid[cand]) pick = cand;
    end
  end
  assign next_g        = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign req_ready     = (state_q == REQ) ? NUM_REQ'(bus_in_ready) << grant_q : '0;
  assign bus_in_valid  = state_q == REQ & req_valid[grant_q];
  assign bus_in_data   = req_data[8*grant_q +: 8];
  assign rsp_valid     = (state_q == RSP) ? NUM_REQ'(bus_out_valid) << grant_q : '0;
  assign rsp_data      = {NUM_REQ{bus_out_data}};
  assign bus_out_ready = state_q == IDLE | (state_q == RSP & rsp_ready[grant_q]);
  assign grant_id      = grant_q;
  assign busy          = state_q != IDLE;
  assign timeout_pulse = tmo;
  // one tracker serves both directions; it is never fed in IDLE
  assign trk_xfer = (state_q == REQ) ? bus_in_valid & bus_in_ready
                                     : state_q == RSP & bus_out_valid & bus_out_ready;
  assign trk_data = (state_q == REQ) ? bus_in_data : bus_out_data;
  assign trk_clr  = state_q == IDLE | tmo;
  bytes_eop_tracker u_trk (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .clr        (trk_clr),
    .xfer       (trk_xfer),
    .data       (trk_data),
    .last       (trk_last)
  );
`ifdef BSARB_TIMEOUT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) cnt_q <= '0;
    else cnt_q <= (state_q != RSP || trk_xfer) ? '0 : cnt_q + 32'd1;
  assign tmo = state_q == RSP && cnt_q == 32'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0 && TIMEOUT_CYCLES != 0;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: if (|req_valid) begin
        state_d = REQ;
        grant_d = pick;
      end
      REQ: state_d = trk_last ? RSP : REQ;
      RSP: if (trk_last || tmo) begin
        state_d = IDLE;
        rr_d    = next_g;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
endmodule

// File: tb/tb_byte_stream_arbiter.sv
// tb_byte_stream_arbiter: scoreboard bench for byte_stream_arbiter (define BSARB_TIMEOUT_EN to add the watchdog case).
module tb_byte_stream_arbiter;
  localparam int NR = 2;
  logic clk = 1'b0, reset_reset = 1'b1;
  logic [NR-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '1;
  logic [8*NR-1:0] req_data = '0, rsp_data;
  logic bus_in_valid, bus_in_ready = 1'b1, bus_out_valid = 1'b0, bus_out_ready;
  logic [7:0] bus_in_data, bus_out_data = '0;
  logic [0:0] grant_id;
  logic busy, timeout_pulse;
  int total = 0, bad = 0;
  logic [7:0] src [NR][$];
  logic [7:0] brq[$], exp_in[$];
  logic [15:0] exp_rsp[$];
  logic in_toggle = 1'b0, watch1 = 1'b0, seen1 = 1'b0;

  always #5 clk = ~clk;

  byte_stream_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16)) dut (
    .clk_clk(clk), .reset_reset(reset_reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .bus_in_valid(bus_in_valid), .bus_in_data(bus_in_data), .bus_in_ready(bus_in_ready),
    .bus_out_valid(bus_out_valid), .bus_out_data(bus_out_data), .bus_out_ready(bus_out_ready),
    .grant_id(grant_id), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic expired(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic put_src(input int id, input int n, input logic [63:0] v);
    for (int k = 0; k < n; k++) src[id].push_back(v[8*(n-1-k) +: 8]);
  endtask

  task automatic put_exp(input int n, input logic [63:0] v);
    for (int k = 0; k < n; k++) exp_in.push_back(v[8*(n-1-k) +: 8]);
  endtask

  task automatic respond(input int id, input int n, input logic [63:0] v);
    for (int k = 0; k < n; k++) begin
      brq.push_back(v[8*(n-1-k) +: 8]);
      exp_rsp.push_back({8'(id), v[8*(n-1-k) +: 8]});
    end
  endtask

  task automatic wait_in(input int n);
    int c = 0;
    while (exp_in.size() > n && c < 300) begin tick(); c++; end
    if (c >= 300) expired("wait_request_bytes");
  endtask

  task automatic wait_busy();
    int c = 0;
    while (!busy && c < 50) begin tick(); c++; end
    if (c >= 50) expired("wait_busy");
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((busy || brq.size() != 0 || exp_rsp.size() != 0) && c < 300) begin tick(); c++; end
    if (c >= 300) expired("wait_idle");
  endtask

  // requester and bridge models: transfers are sampled just before the edge, queues advance after it
  always begin : drv
    logic [NR-1:0] f;
    logic bf;
    @(negedge clk);
    f  = req_valid & req_ready;
    bf = bus_out_valid & bus_out_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (f[i] && src[i].size() != 0) void'(src[i].pop_front());
      req_valid[i] = src[i].size() != 0;
      req_data[8*i +: 8] = (src[i].size() != 0) ? src[i][0] : 8'h00;
    end
    if (bf && brq.size() != 0) void'(brq.pop_front());
    bus_out_valid = brq.size() != 0;
    bus_out_data  = (brq.size() != 0) ? brq[0] : 8'h00;
    bus_in_ready  = in_toggle ? ~bus_in_ready : 1'b1;
  end

  always @(negedge clk) begin : mon
    if (bus_in_valid && bus_in_ready) begin
      if (exp_in.size() == 0) begin
        total++; bad++;
        $display("FAIL bus_in_extra: got %02h want no byte at %0t", bus_in_data, $time);
      end else chk("bus_in_byte", bus_in_data, exp_in.pop_front());
    end
    for (int i = 0; i < NR; i++)
      if (rsp_valid[i] && rsp_ready[i]) begin
        if (exp_rsp.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_extra: got id %0d byte %02h want no byte at %0t", i, rsp_data[8*i +: 8], $time);
        end else chk("rsp_id_byte", {8'(i), rsp_data[8*i +: 8]}, exp_rsp.pop_front());
      end
    if (watch1) seen1 = seen1 | req_ready[1];
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset_reset = 1'b0;
    tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_bus_in_valid", bus_in_valid, 0);
    chk("rst_timeout", timeout_pulse, 0);
    chk("rst_bus_out_ready", bus_out_ready, 1);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);

    // single requester
    put_src(0, 4, 64'h7A017B02);
    put_exp(4, 64'h7A017B02);
    wait_busy();
    chk("t1_grant", grant_id, 0);
    wait_in(0);
    respond(0, 4, 64'h7A107B11);
    wait_idle();
    chk("t1_idle", busy, 0);

    // pointer advanced to 1: requester 1 wins a simultaneous request
    put_src(0, 4, 64'h7A037B04);
    put_src(1, 4, 64'h7A057B06);
    put_exp(4, 64'h7A057B06);
    put_exp(4, 64'h7A037B04);
    wait_busy();
    chk("rr_grant_first", grant_id, 1);
    wait_in(4);
    respond(1, 4, 64'h7A157B16);
    wait_idle();
    wait_busy();
    chk("rr_grant_second", grant_id, 0);
    wait_in(0);
    respond(0, 4, 64'h7A177B18);
    wait_idle();

    // both valid out of reset, one IDLE cycle between transactions
    reset_reset = 1'b1;
    tick();
    reset_reset = 1'b0;
    watch1 = 1'b1;
    seen1  = 1'b0;
    put_src(0, 4, 64'h7A217B22);
    put_src(1, 4, 64'h7A237B24);
    put_exp(4, 64'h7A217B22);
    put_exp(4, 64'h7A237B24);
    wait_busy();
    chk("t2_grant0", grant_id, 0);
    wait_in(4);
    respond(0, 4, 64'h7A317B32);
    wait_idle();
    watch1 = 1'b0;
    chk("t2_rdy1_low", seen1, 0);
    n = 1;
    while (!busy && n < 10) begin tick(); if (!busy) n++; end
    chk("t2_idle_gap", n, 1);
    chk("t2_grant1", grant_id, 1);
    wait_in(0);
    respond(1, 4, 64'h7A337B34);
    wait_idle();

    // escaped EOP in the request; escaped raw 0x7B in the response
    put_src(0, 7, 64'h7A7D5B017B7D5A);
    put_exp(7, 64'h7A7D5B017B7D5A);
    wait_in(3);
    chk("t3_no_end_at_5b", bus_out_ready, 0);
    wait_in(0);
    chk("t3_still_req", bus_out_ready, 0);
    tick();
    chk("t3_rsp_busy", busy, 1);
    chk("t3_rsp_ready", bus_out_ready, 1);
    respond(0, 6, 64'h7A7D7B447B45);
    wait_idle();

    // backpressure on both sides
    in_toggle = 1'b1;
    put_src(1, 5, 64'h7A0203_7B04);
    put_exp(5, 64'h7A0203_7B04);
    wait_in(0);
    in_toggle = 1'b0;
    respond(1, 6, 64'h7A2021227B23);
    while (exp_rsp.size() > 3) tick();
    rsp_ready[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_stall_bus_out_ready", bus_out_ready, 0);
    end
    rsp_ready[1] = 1'b1;
    wait_idle();

    // reset after two response bytes
    put_src(1, 4, 64'h7A057B06);
    put_exp(4, 64'h7A057B06);
    wait_in(0);
    respond(1, 2, 64'h7A50);
    n = 0;
    while (exp_rsp.size() != 0 && n < 50) begin tick(); n++; end
    tick();
    reset_reset = 1'b1;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_grant", grant_id, 0);
    chk("t5_req_ready", req_ready, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_bus_in_valid", bus_in_valid, 0);
    chk("t5_bus_out_ready", bus_out_ready, 1);
    reset_reset = 1'b0;
    put_src(1, 4, 64'h7A077B08);
    put_exp(4, 64'h7A077B08);
    wait_busy();
    chk("t5_regrant", grant_id, 1);
    wait_in(0);
    respond(1, 4, 64'h7A607B61);
    wait_idle();

`ifdef BSARB_TIMEOUT_EN
    put_src(0, 4, 64'h7A097B0A);
    put_exp(4, 64'h7A097B0A);
    wait_in(0);
    n = 0;
    do begin tick(); n++; end while (!timeout_pulse && n < 40);
    chk("t6_timeout_cycle", n, 16);
    tick();
    chk("t6_pulse_width", timeout_pulse, 0);
    chk("t6_idle", busy, 0);
    brq.push_back(8'h7A);
    brq.push_back(8'h99);
    brq.push_back(8'h7B);
    brq.push_back(8'h98);
    tick();
    chk("t6_drop_ready", bus_out_ready, 1);
    n = 0;
    while (brq.size() != 0 && n < 50) begin tick(); n++; end
    tick();
    chk("t6_stray_idle", busy, 0);
`endif

    chk("end_exp_in_empty", exp_in.size(), 0);
    chk("end_exp_rsp_empty", exp_rsp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/byte_stream_arbiter.md
# byte_stream_arbiter

Round-robin scheduler that shares the single Avalon-ST byte-stream port pair of the packet/master bridge (`in_bytes_stream_*` / `out_bytes_stream_*`) between NUM_REQ host byte streams, such as the UART and SPI command links. It grants one requester at a time and holds the grant for one whole request packet plus the matching response packet. It then releases the grant and advances the round-robin pointer. It sits between the host-link receivers/transmitters and the bridge, and is packet-aware through the bridge's byte-level framing: 0x7A SOP, 0x7B EOP, 0x7C channel, 0x7D escape.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- TIMEOUT_CYCLES, 1000000, response watchdog limit (used only with the timeout feature)
- clk_clk  in  1  system clock
- reset_reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte, requester i at [8i+7:8i]
- req_ready  out  NUM_REQ  per-requester ready
- rsp_valid  out  NUM_REQ  response byte valid toward requester
- rsp_data  out  8*NUM_REQ  response byte, same packing as req_data
- rsp_ready  in  NUM_REQ  requester accepts response byte
- bus_in_valid / bus_in_data[7:0]  out  1/8  to bridge in_bytes_stream_valid/data
- bus_in_ready  in  1  from bridge in_bytes_stream_ready
- bus_out_valid / bus_out_data[7:0]  in  1/8  from bridge out_bytes_stream_valid/data
- bus_out_ready  out  1  to bridge out_bytes_stream_ready
- grant_id  out  $clog2(NUM_REQ)  current/last grantee
- busy  out  1  state != IDLE
- timeout_pulse  out  1  one-cycle pulse on watchdog expiry (tied 0 when the feature is excluded)

## Operation
- States: IDLE, REQ, RSP.
- IDLE:
  - req_ready = 0.
  - bus_out_ready = 1; stray response bytes are consumed and dropped.
  - If any req_valid is high, select the first set bit at or after rr_ptr (wrapping), register grant_id, and go to REQ.
- REQ: combinational pass-through of the granted requester.
  - bus_in_valid = req_valid[g], bus_in_data = req_data[g], req_ready[g] = bus_in_ready.
  - All other req_ready = 0; bus_out_ready = 0.
- Packet-end tracker, fed by each transferred byte (valid & ready):
  - After 0x7B is seen, the next byte is the final byte.
  - If that next byte is 0x7D, the byte after it is the final byte.
  - A 0x7D outside EOP context makes the following byte literal, so an escaped 0x7B does not arm the tracker.
- REQ → RSP on the transfer of the request's final byte; the tracker is cleared.
- RSP: pass-through of the bridge response to the grantee.
  - rsp_valid[g] = bus_out_valid, rsp_data[g] = bus_out_data, bus_out_ready = rsp_ready[g].
  - Other rsp_valid = 0.
- RSP → IDLE on the transfer of the response's final byte. Set rr_ptr = (g+1) mod NUM_REQ.
- Requesters that are not granted stall with req_ready low; their bytes are never dropped.
- Reset mid-packet: state → IDLE, rr_ptr = 0, tracker cleared, watchdog cleared. Partial packets are lost; requesters must resynchronise on SOP.

## Timing
- Reset values: all req_ready, rsp_valid, bus_in_valid, timeout_pulse = 0; bus_out_ready = 1 (IDLE); grant_id = 0; busy = 0.
- Arbitration latency: the first request byte can transfer in the cycle after req_valid rises in IDLE. The byte is held by the requester, not registered.
- Data paths add zero latency; ready and valid are combinational through the block.
- Back-to-back transactions: the cycle after RSP → IDLE is one IDLE cycle, then the next grant.
- A req_valid that drops in IDLE while arbitration is pending does not cancel the grant; the block waits in REQ.

## Configuration
- BSARB_TIMEOUT_EN defined:
  - A 32-bit counter runs in RSP and clears on every response byte transfer.
  - When it reaches TIMEOUT_CYCLES-1: pulse timeout_pulse for 1 cycle, go to IDLE, advance rr_ptr, clear the tracker.
  - A late response then arrives in IDLE and is dropped.
- BSARB_TIMEOUT_EN undefined: no counter; RSP waits indefinitely; timeout_pulse is tied 0.

## Structure
- Shared package bsarb_pkg holds:
  - state enum {IDLE, REQ, RSP}
  - localparams BS_SOP=8'h7A, BS_EOP=8'h7B, BS_CHAN=8'h7C, BS_ESC=8'h7D
- Sub-module bytes_eop_tracker:
  - Inputs: clk_clk, reset_reset, clr, xfer, data.
  - Output: last, asserted combinationally on a transfer of the final byte.
  - The top level instantiates one tracker and muxes its input between the request side and the response side by state.

## Test plan
- Single requester 0 sends 7A 01 7B 02 → bridge sees 4 bytes, busy rises. The response 7A 10 7B 11 is routed to rsp 0 only; back to IDLE, rr_ptr = 1.
- Requesters 0 and 1 both valid from reset → grant 0 first and complete; then grant 1 with exactly one IDLE cycle between; req_ready[1] stays 0 throughout transaction 0.
- Escaped EOP: request 7A 7D 5B 01 7B 7D 5A → the transaction does not end at byte 5B; it ends on 5A (byte 7).
- Backpressure: bus_in_ready toggles 1010… and rsp_ready holds 0 for 5 cycles mid-response → no bytes lost or duplicated; order is preserved.
- Reset asserted during RSP after 2 response bytes → next cycle busy = 0, all outputs at reset values; a new packet from requester 1 is granted normally.
- With BSARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16: the response never arrives → timeout_pulse is high for exactly 1 cycle, 16 cycles after RSP entry; a later stray response is dropped with bus_out_ready = 1.
